// File: rtl/alien_fleet_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet_ctrl_pkg
//  Description : Shared constants for the alien formation controller and the
//                alien instances: state encodings, play-mode code, barrier
//                line, playfield edges and the step-period helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alien_fleet_ctrl_pkg;

  typedef logic [2:0] fleet_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RIGHT  = 3'd1;
  localparam logic [2:0] ST_DROP_R = 3'd2;
  localparam logic [2:0] ST_LEFT   = 3'd3;
  localparam logic [2:0] ST_DROP_L = 3'd4;
  localparam logic [2:0] ST_WIN    = 3'd5;
  localparam logic [2:0] ST_LOSE   = 3'd6;

  localparam logic [1:0]  PLAY_MODE   = 2'd2;
  localparam logic [10:0] BARRIER_TOP = 11'd340;

  // Horizontal limits at which an alien raises is_edge.
  localparam logic [10:0] LEFT_EDGE  = 11'd16;
  localparam logic [10:0] RIGHT_EDGE = 11'd624;

  // Frames per step, shrinking with kills and saturating at the floor.
  function automatic logic [15:0] calc_period(input logic [15:0] kills,
                                              input logic [15:0] base_p,
                                              input logic [15:0] min_p,
                                              input logic [15:0] speedup);
    logic [15:0] dec;
    dec = kills * speedup;
    if ((dec >= base_p) || ((base_p - dec) < min_p))
      return min_p;
    return base_p - dec;
  endfunction

  // True for the four states in which the fleet is actively marching.
  function automatic logic is_marching(input fleet_state_t st);
    return (st == ST_RIGHT) || (st == ST_DROP_R) ||
           (st == ST_LEFT)  || (st == ST_DROP_L);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alien_fleet_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet_ctrl_if
//  Description : Bundle between the mode FSM / scan / alien array (master)
//                and the formation controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alien_fleet_ctrl_if #(
  parameter int NUM_ALIENS = 16
) ();
  logic [1:0]            mode;
  logic [10:0]           xCoord;
  logic [10:0]           yCoord;
  logic                  edge_hit;
  logic [NUM_ALIENS-1:0] alien_alive;
  logic [10:0]           fleet_bottom_y;
  logic                  move_left;
  logic                  move_right;
  logic                  move_down;
  logic                  step;
  logic                  fleet_cleared;
  logic                  invaded;

  modport master (
    output mode, xCoord, yCoord, edge_hit, alien_alive, fleet_bottom_y,
    input  move_left, move_right, move_down, step, fleet_cleared, invaded
  );

  modport slave (
    input  mode, xCoord, yCoord, edge_hit, alien_alive, fleet_bottom_y,
    output move_left, move_right, move_down, step, fleet_cleared, invaded
  );
endinterface
`default_nettype wire

// File: rtl/alien_fleet_ctrl_popcount_n.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_n
//  Description : Parameterised population count of an N-bit vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_n #(
  parameter  int N = 16,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_count
);
  // Sum the set bits.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++)
      o_count = o_count + W'(i_bits[i]);
  end
endmodule
`default_nettype wire

// File: rtl/alien_fleet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet_ctrl
//  Description : Alien formation controller. Marches the grid right/down/
//                left/down at a step rate that speeds up with kills, and
//                folds alive mask and fleet depth into win / lose.
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_fleet_ctrl #(
  parameter int          NUM_ALIENS  = 16,
  parameter int          BASE_PERIOD = 100,
  parameter int          MIN_PERIOD  = 10,
  parameter int          SPEEDUP     = 5,
  parameter logic [10:0] BARRIER_TOP = alien_fleet_ctrl_pkg::BARRIER_TOP
) (
  input logic               clk,
  input logic               rst,
  alien_fleet_ctrl_if.slave bus
);
  import alien_fleet_ctrl_pkg::*;

  localparam int CW = $clog2(NUM_ALIENS + 1);

  logic [CW-1:0] alive_cnt;
  logic [15:0]   kills;
  logic [15:0]   period;
  logic          playing;
  logic          at_origin;

  logic          at_origin_q, at_origin_d;
  logic          frame_tick_q, frame_tick_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          step_q, step_d;
  logic [2:0]    state_q, state_d;
  logic          move_left_q, move_left_d;
  logic          move_right_q, move_right_d;
  logic          move_down_q, move_down_d;
  logic          fleet_cleared_q, fleet_cleared_d;
  logic          invaded_q, invaded_d;

  popcount_n #(.N(NUM_ALIENS)) u_popcount (
    .i_bits  (bus.alien_alive),
    .o_count (alive_cnt)
  );

  assign kills   = 16'(NUM_ALIENS) - 16'(alive_cnt);
  assign period  = calc_period(kills, 16'(BASE_PERIOD), 16'(MIN_PERIOD), 16'(SPEEDUP));
  assign playing = (bus.mode == PLAY_MODE);

  // Next-state logic: frame tick detection, formation FSM, step counter, outputs.
  always_comb begin
    at_origin    = (bus.xCoord == 11'd0) && (bus.yCoord == 11'd0);
    at_origin_d  = at_origin;
    frame_tick_d = at_origin && !at_origin_q;

    // Clearing wins over invading; both end states hold until play stops.
    state_d = state_q;
    if (!playing)
      state_d = ST_IDLE;
    else if (bus.alien_alive == '0)
      state_d = ST_WIN;
    else if (state_q == ST_WIN)
      state_d = ST_WIN;
    else if (bus.fleet_bottom_y >= BARRIER_TOP)
      state_d = ST_LOSE;
    else begin
      case (state_q)
        ST_IDLE:   state_d = ST_RIGHT;
        ST_RIGHT:  if (step_q && bus.edge_hit) state_d = ST_DROP_R;
        ST_DROP_R: if (step_q) state_d = ST_LEFT;
        ST_LEFT:   if (step_q && bus.edge_hit) state_d = ST_DROP_L;
        ST_DROP_L: if (step_q) state_d = ST_RIGHT;
        ST_LOSE:   state_d = ST_LOSE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Count frames only while marching; a shrunken period fires on the next tick.
    frame_cnt_d = frame_cnt_q;
    step_d      = 1'b0;
    if (!is_marching(state_q) || !is_marching(state_d))
      frame_cnt_d = 16'd0;
    else if (frame_tick_q) begin
      if ((frame_cnt_q + 16'd1) >= period) begin
        frame_cnt_d = 16'd0;
        step_d      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end

    move_right_d    = (state_d == ST_RIGHT);
    move_left_d     = (state_d == ST_LEFT);
    move_down_d     = (state_d == ST_DROP_R) || (state_d == ST_DROP_L);
    fleet_cleared_d = (state_d == ST_WIN);
    invaded_d       = (state_d == ST_LOSE);
  end

  // State and output registers; reset drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_origin_q     <= 1'b0;
      frame_tick_q    <= 1'b0;
      frame_cnt_q     <= 16'd0;
      step_q          <= 1'b0;
      state_q         <= ST_IDLE;
      move_left_q     <= 1'b0;
      move_right_q    <= 1'b0;
      move_down_q     <= 1'b0;
      fleet_cleared_q <= 1'b0;
      invaded_q       <= 1'b0;
    end else begin
      at_origin_q     <= at_origin_d;
      frame_tick_q    <= frame_tick_d;
      frame_cnt_q     <= frame_cnt_d;
      step_q          <= step_d;
      state_q         <= state_d;
      move_left_q     <= move_left_d;
      move_right_q    <= move_right_d;
      move_down_q     <= move_down_d;
      fleet_cleared_q <= fleet_cleared_d;
      invaded_q       <= invaded_d;
    end
  end

  assign bus.move_left     = move_left_q;
  assign bus.move_right    = move_right_q;
  assign bus.move_down     = move_down_q;
  assign bus.step          = step_q;
  assign bus.fleet_cleared = fleet_cleared_q;
  assign bus.invaded       = invaded_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_fleet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alien_fleet_ctrl
//  Description : Directed bench for alien_fleet_ctrl (16- and 32-alien
//                instances sharing one scan).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_fleet_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   step_count  = 0;
  int   step2_count = 0;

  alien_fleet_ctrl_if #(.NUM_ALIENS(16)) bus  ();
  alien_fleet_ctrl_if #(.NUM_ALIENS(32)) bus2 ();

  alien_fleet_ctrl #(.NUM_ALIENS(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  alien_fleet_ctrl #(.NUM_ALIENS(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.step === 1'b1)  step_count  <= step_count + 1;
    if (bus2.step === 1'b1) step2_count <= step2_count + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_scan(input logic [10:0] x, input logic [10:0] y);
    bus.xCoord  = x;  bus.yCoord  = y;
    bus2.xCoord = x;  bus2.yCoord = y;
  endtask

  task automatic held_frame(input int hold);
    set_scan(11'd0, 11'd0);
    cyc(hold);
    set_scan(11'd1, 11'd0);
    cyc(2);
  endtask

  task automatic frames(input int n);
    repeat (n) held_frame(1);
  endtask

  task automatic fresh_game;
    bus.mode = 2'd1;
    cyc(1);
    bus.mode = 2'd2;
    cyc(1);
  endtask

  task automatic test_reset;
    logic [5:0] outs;
    bus.mode = 2'd0;  bus.edge_hit = 1'b0;  bus.alien_alive = 16'hFFFF;  bus.fleet_bottom_y = 11'd0;
    bus2.mode = 2'd0; bus2.edge_hit = 1'b0; bus2.alien_alive = 32'h3;    bus2.fleet_bottom_y = 11'd0;
    set_scan(11'd1, 11'd0);
    rst = 1'b1;
    cyc(3);
    outs = {bus.move_left, bus.move_right, bus.move_down, bus.step, bus.fleet_cleared, bus.invaded};
    n_checks++;
    if (outs !== 6'b0) begin
      $display("FAIL reset_outputs got %b want %b", outs, 6'b0); n_fails++;
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_march_right;
    int s0;
    bus.mode = 2'd2;
    cyc(1);
    n_checks++;
    if (bus.move_right !== 1'b1) begin
      $display("FAIL idle_to_right got %b want 1", bus.move_right); n_fails++;
    end
    s0 = step_count;
    frames(99);
    n_checks++;
    if (step_count - s0 !== 0) begin
      $display("FAIL steps_99_frames got %0d want 0", step_count - s0); n_fails++;
    end
    frames(1);
    n_checks++;
    if (step_count - s0 !== 1) begin
      $display("FAIL steps_100_frames got %0d want 1", step_count - s0); n_fails++;
    end
    frames(200);
    n_checks++;
    if (step_count - s0 !== 3) begin
      $display("FAIL steps_300_frames got %0d want 3", step_count - s0); n_fails++;
    end
    n_checks++;
    if ({bus.move_left, bus.move_right, bus.move_down} !== 3'b010) begin
      $display("FAIL right_held got %b want 010", {bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
  endtask

  task automatic test_edge_drop;
    bus.edge_hit = 1'b1;
    frames(100);
    n_checks++;
    if ({bus.move_left, bus.move_right, bus.move_down} !== 3'b001) begin
      $display("FAIL drop_r got %b want 001", {bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
    frames(99);
    n_checks++;
    if ({bus.move_left, bus.move_right, bus.move_down} !== 3'b001) begin
      $display("FAIL drop_r_held got %b want 001", {bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
    frames(1);
    n_checks++;
    if ({bus.move_left, bus.move_right, bus.move_down} !== 3'b100) begin
      $display("FAIL drop_r_to_left got %b want 100", {bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
    frames(100);
    n_checks++;
    if ({bus.move_left, bus.move_right, bus.move_down} !== 3'b001) begin
      $display("FAIL drop_l got %b want 001", {bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
    bus.edge_hit = 1'b0;
    frames(100);
    n_checks++;
    if ({bus.move_left, bus.move_right, bus.move_down} !== 3'b010) begin
      $display("FAIL drop_l_to_right got %b want 010", {bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
  endtask

  task automatic test_speedup;
    int s0;
    bus.alien_alive = 16'h0FFF;
    s0 = step_count;
    frames(79);
    n_checks++;
    if (step_count - s0 !== 0) begin
      $display("FAIL period80_early got %0d want 0", step_count - s0); n_fails++;
    end
    frames(1);
    n_checks++;
    if (step_count - s0 !== 1) begin
      $display("FAIL period80_step got %0d want 1", step_count - s0); n_fails++;
    end
    frames(30);
    bus.alien_alive = 16'h0001;
    s0 = step_count;
    frames(1);
    n_checks++;
    if (step_count - s0 !== 1) begin
      $display("FAIL shrink_mid_count got %0d want 1", step_count - s0); n_fails++;
    end
    frames(24);
    n_checks++;
    if (step_count - s0 !== 1) begin
      $display("FAIL period25_early got %0d want 1", step_count - s0); n_fails++;
    end
    frames(1);
    n_checks++;
    if (step_count - s0 !== 2) begin
      $display("FAIL period25_step got %0d want 2", step_count - s0); n_fails++;
    end
    bus2.mode = 2'd2;
    cyc(1);
    s0 = step2_count;
    frames(9);
    n_checks++;
    if (step2_count - s0 !== 0) begin
      $display("FAIL floor10_early got %0d want 0", step2_count - s0); n_fails++;
    end
    frames(1);
    n_checks++;
    if (step2_count - s0 !== 1) begin
      $display("FAIL floor10_step got %0d want 1", step2_count - s0); n_fails++;
    end
    frames(10);
    n_checks++;
    if (step2_count - s0 !== 2) begin
      $display("FAIL floor10_second got %0d want 2", step2_count - s0); n_fails++;
    end
  endtask

  task automatic test_win_lose;
    bus.fleet_bottom_y = 11'd339;
    cyc(1);
    n_checks++;
    if ({bus.invaded, bus.move_right} !== 2'b01) begin
      $display("FAIL barrier_339 got %b want 01", {bus.invaded, bus.move_right}); n_fails++;
    end
    bus.fleet_bottom_y = 11'd340;
    cyc(1);
    n_checks++;
    if ({bus.invaded, bus.fleet_cleared, bus.move_left, bus.move_right, bus.move_down} !== 5'b10000) begin
      $display("FAIL invade_340 got %b want 10000",
               {bus.invaded, bus.fleet_cleared, bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
    bus.fleet_bottom_y = 11'd0;
    cyc(1);
    n_checks++;
    if (bus.invaded !== 1'b1) begin
      $display("FAIL lose_sticky got %b want 1", bus.invaded); n_fails++;
    end
    bus.mode = 2'd1;
    cyc(1);
    n_checks++;
    if (bus.invaded !== 1'b0) begin
      $display("FAIL lose_cleared_by_mode got %b want 0", bus.invaded); n_fails++;
    end
    bus.mode = 2'd2;
    cyc(1);
    bus.alien_alive = 16'h0000;
    bus.fleet_bottom_y = 11'd340;
    cyc(1);
    n_checks++;
    if ({bus.fleet_cleared, bus.invaded, bus.move_right} !== 3'b100) begin
      $display("FAIL win_priority got %b want 100", {bus.fleet_cleared, bus.invaded, bus.move_right}); n_fails++;
    end
    bus.alien_alive = 16'h0001;
    cyc(1);
    n_checks++;
    if ({bus.fleet_cleared, bus.invaded} !== 2'b10) begin
      $display("FAIL win_sticky got %b want 10", {bus.fleet_cleared, bus.invaded}); n_fails++;
    end
    bus.fleet_bottom_y = 11'd0;
    bus.mode = 2'd1;
    cyc(1);
    n_checks++;
    if (bus.fleet_cleared !== 1'b0) begin
      $display("FAIL win_cleared_by_mode got %b want 0", bus.fleet_cleared); n_fails++;
    end
  endtask

  task automatic test_frame_tick_and_mode;
    int s0;
    bus.alien_alive = 16'h0001;
    fresh_game();
    s0 = step_count;
    frames(22);
    held_frame(4);
    n_checks++;
    if (step_count - s0 !== 0) begin
      $display("FAIL held_origin_single_tick got %0d want 0", step_count - s0); n_fails++;
    end
    frames(2);
    n_checks++;
    if (step_count - s0 !== 1) begin
      $display("FAIL held_origin_step got %0d want 1", step_count - s0); n_fails++;
    end
    frames(10);
    bus.mode = 2'd1;
    cyc(1);
    n_checks++;
    if ({bus.move_left, bus.move_right, bus.move_down} !== 3'b000) begin
      $display("FAIL mode_exit_idle got %b want 000", {bus.move_left, bus.move_right, bus.move_down}); n_fails++;
    end
    bus.mode = 2'd2;
    cyc(1);
    n_checks++;
    if (bus.move_right !== 1'b1) begin
      $display("FAIL mode_reenter_right got %b want 1", bus.move_right); n_fails++;
    end
    s0 = step_count;
    frames(24);
    n_checks++;
    if (step_count - s0 !== 0) begin
      $display("FAIL counter_restart_early got %0d want 0", step_count - s0); n_fails++;
    end
    frames(1);
    n_checks++;
    if (step_count - s0 !== 1) begin
      $display("FAIL counter_restart_step got %0d want 1", step_count - s0); n_fails++;
    end
  endtask

  task automatic test_async_reset;
    int s0;
    logic [5:0] outs;
    bus.alien_alive = 16'hFFFF;
    fresh_game();
    frames(50);
    s0 = step_count;
    #2;
    rst = 1'b1;
    #1;
    outs = {bus.move_left, bus.move_right, bus.move_down, bus.step, bus.fleet_cleared, bus.invaded};
    n_checks++;
    if (outs !== 6'b0) begin
      $display("FAIL async_reset_outputs got %b want %b", outs, 6'b0); n_fails++;
    end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    n_checks++;
    if (bus.move_right !== 1'b1) begin
      $display("FAIL after_reset_right got %b want 1", bus.move_right); n_fails++;
    end
    frames(51);
    n_checks++;
    if (step_count - s0 !== 0) begin
      $display("FAIL after_reset_no_step got %0d want 0", step_count - s0); n_fails++;
    end
  endtask

  initial begin
    test_reset();
    test_march_right();
    test_edge_drop();
    test_speedup();
    test_win_lose();
    test_frame_tick_and_mode();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
